// File: rtl/sipo_comma_align.sv
// Serial-to-parallel converter with K28.5 comma word alignment.
// Hunts for a comma, then emits one aligned word every NUM_BITS enabled bits.
module sipo_comma_align #(
    parameter int unsigned         NUM_BITS = 10,
    parameter logic [NUM_BITS-1:0] COMMA_P  = NUM_BITS'('h17C),
    parameter logic [NUM_BITS-1:0] COMMA_N  = NUM_BITS'('h283),
    parameter int unsigned         MAX_ERR  = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                bit_en,
    input  logic                data_in,
    input  logic                dir,
    output logic [NUM_BITS-1:0] data_out,
    output logic                data_valid,
    output logic                comma_det,
    output logic                locked
);

    localparam int unsigned CNT_W = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
    localparam int unsigned ERR_W = (MAX_ERR > 1) ? $clog2(MAX_ERR) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(NUM_BITS - 1);
    localparam logic [ERR_W-1:0] ERR_LAST = ERR_W'(MAX_ERR - 1);

    typedef enum logic {StHunt, StLocked} state_e;

    state_e              r_state;
    state_e              w_state_next;
    logic [NUM_BITS-1:0] r_sh;
    logic [NUM_BITS-1:0] r_data_out;
    logic                r_data_valid;
    logic                r_comma_det;
    logic [CNT_W-1:0]    r_bit_cnt;
    logic [CNT_W-1:0]    w_bit_cnt_next;
    logic [ERR_W-1:0]    r_err_cnt;
    logic [ERR_W-1:0]    w_err_cnt_next;
    logic [NUM_BITS-1:0] w_window;
    logic                w_match;
    logic                w_boundary;
    logic                w_err_full;
    logic                w_load;
    logic                w_comma_next;

    // dir=0 fills from the MSB end so the first bit ends up in bit 0.
    assign w_window   = dir ? {r_sh[NUM_BITS-2:0], data_in} : {data_in, r_sh[NUM_BITS-1:1]};
    assign w_match    = (w_window == COMMA_P) || (w_window == COMMA_N);
    assign w_boundary = (r_bit_cnt == LAST_BIT);
    assign w_err_full = (r_err_cnt == ERR_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= StHunt;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (bit_en) begin
            unique case (r_state)
                StHunt:   if (w_match) w_state_next = StLocked;
                StLocked: if (!w_boundary && w_match && w_err_full) w_state_next = StHunt;
                default:  w_state_next = StHunt;
            endcase
        end
    end

    always_comb begin
        w_bit_cnt_next = r_bit_cnt;
        w_err_cnt_next = r_err_cnt;
        w_load         = 1'b0;
        w_comma_next   = 1'b0;
        if (bit_en) begin
            unique case (r_state)
                StHunt: begin
                    if (w_match) begin
                        w_load         = 1'b1;
                        w_comma_next   = 1'b1;
                        w_bit_cnt_next = '0;
                        w_err_cnt_next = '0;
                    end
                end
                StLocked: begin
                    if (w_boundary) begin
                        w_load         = 1'b1;
                        w_comma_next   = w_match;
                        w_bit_cnt_next = '0;
                        if (w_match) w_err_cnt_next = '0;
                    end else if (w_match && w_err_full) begin
                        // Too many misaligned commas: drop lock without realigning here.
                        w_bit_cnt_next = '0;
                        w_err_cnt_next = '0;
                    end else begin
                        w_bit_cnt_next = r_bit_cnt + CNT_W'(1);
                        if (w_match) w_err_cnt_next = r_err_cnt + ERR_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sh         <= '0;
            r_bit_cnt    <= '0;
            r_err_cnt    <= '0;
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
            r_comma_det  <= 1'b0;
        end else begin
            if (bit_en) r_sh <= w_window;
            if (w_load) r_data_out <= w_window;
            r_bit_cnt    <= w_bit_cnt_next;
            r_err_cnt    <= w_err_cnt_next;
            r_data_valid <= w_load;
            r_comma_det  <= w_comma_next;
        end
    end

    assign data_out   = r_data_out;
    assign data_valid = r_data_valid;
    assign comma_det  = r_comma_det;
    assign locked     = (r_state == StLocked);

endmodule
